// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: FSM state encoding, exception codes, PC increment helper.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_ISSUE = 3'd0,
    S_WAIT  = 3'd1,
    S_OUT   = 3'd2,
    S_DRAIN = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [5:0] EXC_INST_MISALIGNED   = 6'd0;
  localparam logic [5:0] EXC_INST_ACCESS_FAULT = 6'd1;
  localparam logic [5:0] EXC_ILLEGAL_INST      = 6'd2;

  // Wraps modulo 2^32 by construction of the 32-bit sum.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter: reset load, redirect mux and +4 advance.
// FETCH_MISALIGN_CHECK_EN keeps redirect targets as-is; otherwise their low two bits are cleared.
module fetch_pc
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_flush,
  input  logic [31:0] i_flush_pc,
  input  logic        i_advance,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;
  logic [31:0] w_flush_tgt;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign w_flush_tgt = i_flush_pc;
`else
  assign w_flush_tgt = i_flush_pc & ~32'h0000_0003;
`endif

  always_ff @(posedge clk) begin
    if (reset)          r_pc <= RESET_PC;
    else if (i_flush)   r_pc <= w_flush_tgt;
    else if (i_advance) r_pc <= pc_inc(r_pc);
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch.sv
// Instruction fetch: one outstanding request, registered output word with back-pressure and redirect.
// FETCH_MISALIGN_CHECK_EN enables the misaligned-PC fetch exception.
//
// state   | meaning
// S_ISSUE | request at PC, wait for grant
// S_WAIT  | granted, wait for response
// S_OUT   | word held on outputs until consumed
// S_DRAIN | redirected with a response still owed; swallow it
// S_HALT  | exception delivered; idle until redirect
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        stall,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic [5:0]  exception_num_out,
  output logic        exception_valid_out,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  state_t      r_state, w_next;
  logic [31:0] w_pc;
  logic        w_req, w_capture, w_mis_take, w_consume, w_misalign;
  logic [31:0] r_inst, r_inst_pc;
  logic [5:0]  r_exc_num;
  logic        r_exc_valid, r_valid;

  fetch_pc #(.RESET_PC(RESET_PC)) u_pc (
    .clk        (clk),
    .reset      (reset),
    .i_flush    (flush),
    .i_flush_pc (flush_pc),
    .i_advance  (w_capture),
    .o_pc       (w_pc)
  );

`ifdef FETCH_MISALIGN_CHECK_EN
  assign w_misalign = (w_pc[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    w_next     = r_state;
    w_req      = 1'b0;
    w_capture  = 1'b0;
    w_mis_take = 1'b0;
    w_consume  = 1'b0;
    case (r_state)
      S_ISSUE: begin
        if (w_misalign) begin
          if (!flush) begin
            w_mis_take = 1'b1;
            w_next     = S_OUT;
          end
        end else begin
          w_req = 1'b1;
          // A grant taken alongside a redirect still owes us a response.
          if (flush)        w_next = mem_gnt ? S_DRAIN : S_ISSUE;
          else if (mem_gnt) w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          w_next = mem_rvalid ? S_ISSUE : S_DRAIN;
        end else if (mem_rvalid) begin
          w_capture = 1'b1;
          w_next    = S_OUT;
        end
      end
      S_OUT: begin
        if (flush) begin
          w_next = S_ISSUE;
        end else if (!stall) begin
          w_consume = 1'b1;
          w_next    = r_exc_valid ? S_HALT : S_ISSUE;
        end
      end
      S_DRAIN: if (mem_rvalid) w_next = S_ISSUE;
      S_HALT:  if (flush)      w_next = S_ISSUE;
      default: w_next = S_ISSUE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_ISSUE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_inst      <= 32'h0;
      r_inst_pc   <= 32'h0;
      r_exc_num   <= 6'd0;
      r_exc_valid <= 1'b0;
      r_valid     <= 1'b0;
    end else if (w_capture) begin
      r_inst      <= mem_err ? 32'h0 : mem_rdata;
      r_inst_pc   <= w_pc;
      r_exc_num   <= mem_err ? EXC_INST_ACCESS_FAULT : 6'd0;
      r_exc_valid <= mem_err;
      r_valid     <= 1'b1;
    end else if (w_mis_take) begin
      r_inst      <= 32'h0;
      r_inst_pc   <= w_pc;
      r_exc_num   <= EXC_INST_MISALIGNED;
      r_exc_valid <= 1'b1;
      r_valid     <= 1'b1;
    end else if (w_consume) begin
      r_valid     <= 1'b0;
    end
  end

  assign mem_req             = w_req & ~reset;
  assign mem_addr            = w_pc;
  assign inst                = r_inst;
  assign inst_pc             = r_inst_pc;
  assign exception_num_out   = r_exc_num;
  assign exception_valid_out = r_exc_valid;
  assign inst_valid          = r_valid & ~flush;

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch with a scoreboard of expected delivered words.
module tb_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic        stall = 1'b0;
  logic [31:0] inst, inst_pc, mem_addr;
  logic        inst_valid, exception_valid_out, mem_req;
  logic [5:0]  exception_num_out;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_err = 1'b0;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        excv;
    logic [5:0]  excn;
  } exp_t;
  exp_t sb[$];

  fetch #(.RESET_PC(32'h100)) dut (
    .clk(clk), .reset(reset), .flush(flush), .flush_pc(flush_pc), .stall(stall),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .exception_num_out(exception_num_out), .exception_valid_out(exception_valid_out),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] i, input logic [31:0] pc, input logic excv, input logic [5:0] excn);
    exp_t e;
    e.inst = i; e.pc = pc; e.excv = excv; e.excn = excn;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    int n = 0;
    while (inst_valid !== 1'b1 && n < 5) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, {31'h0, inst_valid}, 32'h1);
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_inst"}, inst, e.inst);
      chk({tag, "_pc"}, inst_pc, e.pc);
      chk({tag, "_excv"}, {31'h0, exception_valid_out}, {31'h0, e.excv});
      chk({tag, "_excn"}, {26'h0, exception_num_out}, {26'h0, e.excn});
    end
  endtask

  // Starts in ISSUE at a sample point; returns at the sample point of the OUT cycle.
  task automatic fetch_word(input string tag, input logic [31:0] pc, input logic [31:0] data, input logic err);
    chk({tag, "_req"}, {31'h0, mem_req}, 32'h1);
    chk({tag, "_addr"}, mem_addr, pc);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk({tag, "_wait_req"}, {31'h0, mem_req}, 32'h0);
    mem_rvalid = 1'b1; mem_rdata = data; mem_err = err;
    if (err) push_exp(32'h0, pc, 1'b1, 6'd1);
    else     push_exp(data, pc, 1'b0, 6'd0);
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_err = 1'b0;
    check_out(tag);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_exc", {25'h0, exception_valid_out, exception_num_out}, 32'h0);
    reset = 1'b0;
    #1;

    // basic fetch from RESET_PC
    fetch_word("t1", 32'h100, 32'h0000_0013, 1'b0);
    tick();
    chk("t1_next", mem_addr, 32'h104);

    // back-pressure holds the word and blocks requests
    fetch_word("t2", 32'h104, 32'h0000_0022, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_hold_valid", {31'h0, inst_valid}, 32'h1);
      chk("t2_hold_inst", inst, 32'h22);
      chk("t2_hold_pc", inst_pc, 32'h104);
      chk("t2_hold_req", {31'h0, mem_req}, 32'h0);
    end
    stall = 1'b0;
    tick();
    chk("t2_next_req", {31'h0, mem_req}, 32'h1);
    chk("t2_next", mem_addr, 32'h108);

    // redirect while waiting; late response is dropped
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    flush = 1'b1; flush_pc = 32'h200;
    #1;
    chk("t3_flush_valid", {31'h0, inst_valid}, 32'h0);
    tick();
    flush = 1'b0;
    chk("t3_drain_req", {31'h0, mem_req}, 32'h0);
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_DEAD;
    #1;
    chk("t3_drain_valid", {31'h0, inst_valid}, 32'h0);
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    chk("t3_req", {31'h0, mem_req}, 32'h1);
    chk("t3_addr", mem_addr, 32'h200);
    chk("t3_no_dead", {31'h0, inst_valid}, 32'h0);

    // access fault, halt, resume by redirect
    flush = 1'b1; flush_pc = 32'h300;
    tick();
    flush = 1'b0;
    fetch_word("t4", 32'h300, 32'h0000_1234, 1'b1);
    tick();
    chk("t4_halt_req", {31'h0, mem_req}, 32'h0);
    chk("t4_halt_valid", {31'h0, inst_valid}, 32'h0);
    tick();
    chk("t4_halt_req2", {31'h0, mem_req}, 32'h0);
    flush = 1'b1; flush_pc = 32'h0;
    tick();
    flush = 1'b0;
    chk("t4_resume_req", {31'h0, mem_req}, 32'h1);
    chk("t4_resume_addr", mem_addr, 32'h0);

    // PC wrap
    flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
    tick();
    flush = 1'b0;
    fetch_word("t5", 32'hFFFF_FFFC, 32'h0000_0055, 1'b0);
    tick();
    chk("t5_wrap", mem_addr, 32'h0);

    // redirect while holding a stalled word
    fetch_word("t6", 32'h0, 32'h0000_0077, 1'b0);
    stall = 1'b1; flush = 1'b1; flush_pc = 32'h400;
    #1;
    chk("t6_gate", {31'h0, inst_valid}, 32'h0);
    tick();
    flush = 1'b0; stall = 1'b0;
    chk("t6_valid", {31'h0, inst_valid}, 32'h0);
    chk("t6_addr", mem_addr, 32'h400);

    // redirect coinciding with the response
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_BEEF; flush = 1'b1; flush_pc = 32'h500;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0; flush = 1'b0;
    chk("t7_req", {31'h0, mem_req}, 32'h1);
    chk("t7_addr", mem_addr, 32'h500);
    chk("t7_valid", {31'h0, inst_valid}, 32'h0);
    tick();
    chk("t7_valid2", {31'h0, inst_valid}, 32'h0);

    // misaligned redirect target
    flush = 1'b1; flush_pc = 32'h202;
    tick();
    flush = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("t8_no_req", {31'h0, mem_req}, 32'h0);
    push_exp(32'h0, 32'h202, 1'b1, 6'd0);
    tick();
    chk("t8_out_req", {31'h0, mem_req}, 32'h0);
    check_out("t8");
    tick();
    chk("t8_halt_req", {31'h0, mem_req}, 32'h0);
`else
    chk("t8_req", {31'h0, mem_req}, 32'h1);
    chk("t8_addr", mem_addr, 32'h200);
`endif

    // reset abandons an in-flight request
    flush = 1'b1; flush_pc = 32'h600;
    tick();
    flush = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    reset = 1'b1;
    #1;
    chk("t9_rst_req", {31'h0, mem_req}, 32'h0);
    tick();
    chk("t9_rst_valid", {31'h0, inst_valid}, 32'h0);
    reset = 1'b0;
    #1;
    chk("t9_req", {31'h0, mem_req}, 32'h1);
    chk("t9_addr", mem_addr, 32'h100);

    chk("sb_drained", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
